// File: rtl/serial_sub_recover.sv
// Bit-serial subtractor that recovers addend A from an adder result {Cout,S}
// and the other addend B: A = {Cout,S} - B, one bit per clock, LSB first.
module serial_sub_recover #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] S,
    input  logic             Cout,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] A,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_borrow;
    logic [CW-1:0]    r_bitcnt;
    logic [WIDTH-1:0] r_A;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    logic             w_mi;
    logic             w_bi;
    logic             w_di;
    logic             w_borrow_nxt;
    logic             w_last;

    // Full-subtractor cell for the current bit and end-of-shift detect.
    always_comb begin
        w_mi         = r_m[0];
        w_bi         = r_b[0];
        w_di         = w_mi ^ w_bi ^ r_borrow;
        w_borrow_nxt = (~w_mi & w_bi) | (~(w_mi ^ w_bi) & r_borrow);
        w_last       = (r_state == SHIFT) && (r_bitcnt == CW'(WIDTH));
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_bitcnt == CW'(WIDTH)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register; busy/done registered from the next state so they
    // track the state exactly without a combinational output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    // Operand latch, serial shift and result capture.
    // r_d holds only the low WIDTH difference bits; the top bit (D[WIDTH])
    // is the cell output on the final edge and feeds err directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_bitcnt <= '0;
            r_A      <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m      <= {Cout, S};
                        r_b      <= {1'b0, B};
                        r_d      <= '0;
                        r_borrow <= 1'b0;
                        r_bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    r_m      <= r_m >> 1;
                    r_b      <= r_b >> 1;
                    r_d      <= {w_di, r_d[WIDTH-1:1]};
                    r_borrow <= w_borrow_nxt;
                    r_bitcnt <= r_bitcnt + CW'(1);
                    if (w_last) begin
                        r_A   <= r_d;
                        r_err <= w_borrow_nxt | w_di;
                    end
                end
                default: ;
            endcase
        end
    end

    assign A    = r_A;
    assign err  = r_err;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_sub_recover.sv
// Bench for serial_sub_recover: table vectors, random vectors against a
// behavioural model, and hand sequences for handshake and reset corners.
module tb_serial_sub_recover;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] S;
    logic       Cout;
    logic [4:0] B;
    logic [4:0] A;
    logic       err;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    typedef struct packed {
        logic [4:0] a;
        logic       e;
    } exp_t;

    typedef struct {
        logic [4:0] s;
        logic       c;
        logic [4:0] b;
        logic [4:0] a;
        logic       e;
    } vec_t;

    exp_t q[$];

    serial_sub_recover #(.WIDTH(5)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .S    (S),
        .Cout (Cout),
        .B    (B),
        .A    (A),
        .err  (err),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Independent arithmetic reference.
    function automatic exp_t model(input logic [4:0] s, input logic c, input logic [4:0] b);
        int         m;
        int         d;
        logic [5:0] d6;
        exp_t       r;
        m    = int'(c) * 32 + int'(s);
        d    = m - int'(b);
        d6   = 6'(d);
        r.a  = d6[4:0];
        r.e  = (m < int'(b)) || d6[5];
        return r;
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("A", int'(A), int'(e.a));
                chk("err", int'(err), int'(e.e));
            end
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic run_job(input logic [4:0] s, input logic c, input logic [4:0] b,
                           input exp_t e, input bit chk_lat);
        int n;
        q.push_back(e);
        S = s; Cout = c; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        S = ~s; B = ~b; Cout = ~c;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n = k;
                break;
            end
        end
        if (chk_lat) chk("latency", n, 6);
        else if (n == 0) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        if (chk_lat) begin
            chk("done_width", int'(done), 0);
            chk("busy_after", int'(busy), 0);
        end
    endtask

    initial begin
        vec_t tbl[9];
        exp_t e;
        exp_t ex;
        exp_t ey;
        int   base;
        int   k;
        logic [4:0] rs;
        logic [4:0] rb;
        logic       rc;

        tbl[0] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0};
        tbl[1] = '{5'b00011, 1'b0, 5'b00010, 5'b00001, 1'b0};
        tbl[2] = '{5'b01110, 1'b0, 5'b00111, 5'b00111, 1'b0};
        tbl[3] = '{5'b01000, 1'b1, 5'b11000, 5'b10000, 1'b0};
        tbl[4] = '{5'b00001, 1'b0, 5'b00010, 5'b11111, 1'b1};
        tbl[5] = '{5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b1};
        tbl[6] = '{5'b11111, 1'b1, 5'b11111, 5'b00000, 1'b1};
        tbl[7] = '{5'b11111, 1'b0, 5'b11111, 5'b00000, 1'b0};
        tbl[8] = '{5'b00101, 1'b1, 5'b11111, 5'b00110, 1'b0};

        reset = 1'b1; start = 1'b0; S = '0; Cout = 1'b0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A", int'(A), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            e.a = tbl[i].a;
            e.e = tbl[i].e;
            run_job(tbl[i].s, tbl[i].c, tbl[i].b, e, 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            rs = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rc = 1'($urandom_range(0, 1));
            run_job(rs, rc, rb, model(rs, rc, rb), 1'b0);
        end

        // start held for 10 edges; operands change after the first edge.
        base = n_done;
        ex = model(5'b01110, 1'b0, 5'b00111);
        ey = model(5'b11111, 1'b1, 5'b00001);
        q.push_back(ex);
        S = 5'b01110; Cout = 1'b0; B = 5'b00111; start = 1'b1;
        @(posedge clk); #1;
        q.push_back(ey);
        S = 5'b11111; Cout = 1'b1; B = 5'b00001;
        chk("hold_busy", int'(busy), 1);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            chk("hold_busy", int'(busy), 1);
        end
        for (int j = 6; j <= 9; j++) begin
            @(posedge clk); #1;
            if (j == 7) chk("hold_one_done", n_done - base, 1);
        end
        start = 1'b0;
        k = 0;
        for (int j = 0; j < 20 && k == 0; j++) begin
            @(posedge clk); #1;
            if (n_done - base >= 2) k = 1;
        end
        chk("hold_second_done", n_done - base, 2);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_no_extra", n_done - base, 2);

        // Reset on the third SHIFT edge aborts the job.
        base = n_done;
        S = 5'b00011; Cout = 1'b0; B = 5'b00010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_A", int'(A), 0);
        chk("abort_err", int'(err), 0);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", n_done - base, 0);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
